// File: rtl/sar8b_pkg.sv
// sar8b_pkg: shared parameters and types for the SAR result path
package sar8b_pkg;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CNTW = 16;
  localparam int PTRW = $clog2(DEPTH) + 1;
  typedef logic [DW-1:0] sar_code_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser with async active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m <= 1'b0;
      q <= 1'b0;
    end else begin
      m <= d;
      q <= m;
    end
endmodule

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: captures SAR results into the CLK domain and queues them behind a valid/ready port
module sar_result_fifo
  import sar8b_pkg::*;
#(
  parameter int DW    = sar8b_pkg::DW,
  parameter int DEPTH = sar8b_pkg::DEPTH,
  parameter int CNTW  = sar8b_pkg::CNTW
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     FINAL,
  input  logic [DW-1:0]            D,
  input  logic                     EN,
  output logic [DW-1:0]            DOUT,
  output logic                     DVALID,
  input  logic                     DREADY,
  output logic                     OVF,
  input  logic                     CLR_OVF,
  output logic [CNTW-1:0]          CNT,
  output logic [$clog2(DEPTH):0]   LEVEL
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic f2, f3, seen_low, cap, pop, full, empty, acc;
  logic [1:0] warm;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  sync_2ff u_sync (.clk(CLK), .rst_n(RSTN), .d(FINAL), .q(f2));
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      f3       <= 1'b0;
      warm     <= '0;
      seen_low <= 1'b0;
    end else begin
      f3       <= f2;
      warm     <= {warm[0], 1'b1};
      seen_low <= seen_low | (warm[1] & ~f2);
    end
  always_comb begin
    cap   = f2 & ~f3 & EN & seen_low;
    empty = wr_ptr == rd_ptr;
    full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    pop   = ~empty & DREADY;
    acc   = cap & (~full | pop);
  end
  assign DVALID = ~empty;
  assign DOUT   = mem[rd_ptr[PW-2:0]];
  assign LEVEL  = wr_ptr - rd_ptr;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      CNT    <= '0;
      OVF    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (acc) mem[wr_ptr[PW-2:0]] <= D;
      wr_ptr <= wr_ptr + PW'(acc);
      rd_ptr <= rd_ptr + PW'(pop);
      CNT    <= CNT + CNTW'(acc);
      OVF    <= (cap & full & ~pop) | (OVF & ~CLR_OVF);
    end
endmodule

// File: tb/tb_sar_result_fifo.sv
// tb_sar_result_fifo: directed self-checking bench for sar_result_fifo
module tb_sar_result_fifo;
  logic CLK = 1'b0, RSTN = 1'b0, FINAL = 1'b0, EN = 1'b1, DREADY = 1'b0, CLR_OVF = 1'b0;
  logic [7:0] D = '0, DOUT, s_dout;
  logic DVALID, OVF, s_dvalid, s_ovf;
  logic [15:0] CNT;
  logic [2:0] s_cnt, LEVEL, s_level;
  int n_cmp = 0, n_err = 0;
  sar_result_fifo dut (
    .CLK(CLK), .RSTN(RSTN), .FINAL(FINAL), .D(D), .EN(EN),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .OVF(OVF),
    .CLR_OVF(CLR_OVF), .CNT(CNT), .LEVEL(LEVEL)
  );
  sar_result_fifo #(.CNTW(3)) u_small (
    .CLK(CLK), .RSTN(RSTN), .FINAL(FINAL), .D(D), .EN(EN),
    .DOUT(s_dout), .DVALID(s_dvalid), .DREADY(1'b1), .OVF(s_ovf),
    .CLR_OVF(CLR_OVF), .CNT(s_cnt), .LEVEL(s_level)
  );
  always #5 CLK = ~CLK;
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    RSTN = 1'b0;
    tick(2);
    RSTN = 1'b1;
    tick(4);
  endtask
  task automatic conv(input logic [7:0] c);
    D = c;
    FINAL = 1'b1;
    tick(5);
    FINAL = 1'b0;
    tick(3);
  endtask
  initial begin
    tick(2);
    chk("rst_dvalid", DVALID, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_cnt", CNT, 0);
    chk("rst_ovf", OVF, 0);
    RSTN = 1'b1;
    tick(4);
    D = 8'hA5;
    FINAL = 1'b1;
    tick(1);
    chk("lat_k", DVALID, 0);
    tick(1);
    chk("lat_k1", DVALID, 0);
    tick(1);
    chk("lat_k2_dvalid", DVALID, 1);
    chk("lat_dout", DOUT, 8'hA5);
    chk("lat_cnt", CNT, 1);
    chk("lat_level", LEVEL, 1);
    tick(2);
    FINAL = 1'b0;
    tick(3);
    chk("single_level", LEVEL, 1);
    do_reset();
    for (int i = 1; i <= 5; i++) conv(8'(i));
    chk("ovf_level", LEVEL, 4);
    chk("ovf_set", OVF, 1);
    chk("ovf_cnt", CNT, 4);
    DREADY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_dout", DOUT, i);
      tick(1);
    end
    chk("drain_empty", DVALID, 0);
    chk("drain_level", LEVEL, 0);
    tick(1);
    chk("pop_empty_level", LEVEL, 0);
    DREADY = 1'b0;
    CLR_OVF = 1'b1;
    tick(1);
    CLR_OVF = 1'b0;
    chk("ovf_clr", OVF, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) conv(8'(i));
    chk("full_level", LEVEL, 4);
    D = 8'h05;
    FINAL = 1'b1;
    tick(2);
    DREADY = 1'b1;
    tick(1);
    DREADY = 1'b0;
    chk("fullpop_level", LEVEL, 4);
    chk("fullpop_ovf", OVF, 0);
    chk("fullpop_cnt", CNT, 5);
    chk("fullpop_head", DOUT, 8'h02);
    tick(2);
    FINAL = 1'b0;
    tick(3);
    DREADY = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_dout", DOUT, i);
      tick(1);
    end
    chk("fullpop_empty", DVALID, 0);
    DREADY = 1'b0;
    do_reset();
    EN = 1'b0;
    conv(8'h3C);
    chk("en0_level", LEVEL, 0);
    chk("en0_cnt", CNT, 0);
    D = 8'h3C;
    FINAL = 1'b1;
    tick(4);
    EN = 1'b1;
    tick(4);
    chk("en_late_level", LEVEL, 0);
    chk("en_late_cnt", CNT, 0);
    FINAL = 1'b0;
    tick(3);
    D = 8'h11;
    FINAL = 1'b1;
    RSTN = 1'b0;
    tick(2);
    RSTN = 1'b1;
    tick(6);
    chk("rstrel_level", LEVEL, 0);
    chk("rstrel_dvalid", DVALID, 0);
    FINAL = 1'b0;
    tick(4);
    conv(8'h7E);
    tick(3);
    chk("rearm_level", LEVEL, 1);
    chk("rearm_dout", DOUT, 8'h7E);
    chk("rearm_cnt", CNT, 1);
    do_reset();
    for (int i = 1; i <= 5; i++) conv(8'(i));
    chk("ovf2_set", OVF, 1);
    CLR_OVF = 1'b1;
    tick(1);
    CLR_OVF = 1'b0;
    chk("ovf2_clr", OVF, 0);
    D = 8'h06;
    FINAL = 1'b1;
    tick(2);
    CLR_OVF = 1'b1;
    tick(1);
    CLR_OVF = 1'b0;
    chk("ovf_set_wins", OVF, 1);
    chk("ovf2_cnt", CNT, 4);
    chk("ovf2_head", DOUT, 8'h01);
    tick(2);
    FINAL = 1'b0;
    tick(3);
    do_reset();
    DREADY = 1'b1;
    for (int i = 0; i < 7; i++) conv(8'(8'h40 + i));
    chk("wrap_pre", s_cnt, 7);
    conv(8'h47);
    chk("wrap_zero", s_cnt, 0);
    chk("wrap_main_cnt", CNT, 8);
    chk("wrap_main_empty", DVALID, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
